// File: rtl/cond_flag_unit.sv
// Condition/flag unit: NZCV register, ARM condition evaluation, write gating and branch flush.
// Optional `COND_STATS_EN adds saturating executed/skipped instruction counters.
module cond_flag_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               ex_valid,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               NoWrite,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    output logic               CondEx,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [3:0]         Flags,
    output logic               flush
`ifdef COND_STATS_EN
    ,
    output logic [COUNT_W-1:0] exec_count,
    output logic [COUNT_W-1:0] skip_count
`endif
);

    // state  | meaning
    // S_RUN  | normal execution, writes gated by the condition
    // S_FLUSH| squashing wrong-path instructions after a taken branch

    localparam int  CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam bit  HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = HAS_FLUSH ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    if (COUNT_W < 1) begin : g_count_w_invalid
        $error("cond_flag_unit: COUNT_W must be at least 1");
    end

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             cond_pass;
    logic             fire;
    logic             flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Qualifying with reset keeps every write enable low while reset is held.
    assign fire     = reset & ex_valid & ~stall & (state_q == S_RUN);
    assign CondEx   = cond_pass;
    assign PCSrc    = fire & cond_pass & PCS;
    assign RegWrite = fire & cond_pass & RegW & ~NoWrite;
    assign MemWrite = fire & cond_pass & MemW;
    assign Flags    = flags_q;
    assign flush    = (state_q == S_FLUSH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;

        if (fire && cond_pass) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end

        case (state_q)
            S_RUN: begin
                if (PCSrc && HAS_FLUSH) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    if (cnt_q == '0) state_d = S_RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

`ifdef COND_STATS_EN
    logic [COUNT_W-1:0] exec_q, skip_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            if (fire && cond_pass && (exec_q != '1))  exec_q <= exec_q + COUNT_W'(1);
            if (fire && !cond_pass && (skip_q != '1)) skip_q <= skip_q + COUNT_W'(1);
        end
    end

    assign exec_count = exec_q;
    assign skip_count = skip_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: stimulus pushes model expectations, monitor compares at negedge.
module tb_cond_flag_unit;

    localparam int FC = 2;
    localparam int CW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0, ex_valid = 1'b0, NoWrite = 1'b0;
    logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0;
    logic [3:0] Cond = 4'd0, ALUFlags = 4'd0;
    logic [1:0] FlagW = 2'd0;
    logic       CondEx, PCSrc, RegWrite, MemWrite, flush;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [CW-1:0] exec_count, skip_count;
`endif

    cond_flag_unit #(.FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .NoWrite(NoWrite),
        .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .flush(flush)
`ifdef COND_STATS_EN
        , .exec_count(exec_count), .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       condex, pcsrc, regw, memw, flush;
        bit [3:0] flags;
        int       exec, skip;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: architectural flags, remaining squash cycles, statistics
    bit [3:0] m_flags;
    int       m_flush_left;
    int       m_exec, m_skip;

    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("CondEx",   32'(CondEx),   32'(e.condex));
            check("PCSrc",    32'(PCSrc),    32'(e.pcsrc));
            check("RegWrite", 32'(RegWrite), 32'(e.regw));
            check("MemWrite", 32'(MemWrite), 32'(e.memw));
            check("Flags",    32'(Flags),    32'(e.flags));
            check("flush",    32'(flush),    32'(e.flush));
`ifdef COND_STATS_EN
            check("exec_count", 32'(exec_count), 32'(e.exec));
            check("skip_count", 32'(skip_count), 32'(e.skip));
`endif
        end
    end

    task automatic step(input bit [3:0] c, input bit [3:0] af, input bit [1:0] fw,
                        input bit nw, input bit pcs, input bit rw, input bit mw,
                        input bit val, input bit stl);
        exp_t e;
        bit   pass, fire, in_fl;
        @(posedge clk);
        #1;
        Cond = c; ALUFlags = af; FlagW = fw; NoWrite = nw;
        PCS = pcs; RegW = rw; MemW = mw; ex_valid = val; stall = stl;
        pass  = cond_ok(c, m_flags);
        in_fl = (m_flush_left > 0);
        fire  = val && !stl && !in_fl;
        e.condex = pass;
        e.pcsrc  = fire && pass && pcs;
        e.regw   = fire && pass && rw && !nw;
        e.memw   = fire && pass && mw;
        e.flags  = m_flags;
        e.flush  = in_fl;
        e.exec   = m_exec;
        e.skip   = m_skip;
        exp_q.push_back(e);
        if (fire && pass) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
            if (m_exec < (1 << CW) - 1) m_exec++;
        end
        if (fire && !pass && m_skip < (1 << CW) - 1) m_skip++;
        if (in_fl) begin
            if (!stl) m_flush_left--;
        end else if (e.pcsrc && FC > 0) begin
            m_flush_left = FC;
        end
    endtask

    // Drive reset low mid-cycle with a Cond=EQ register-write instruction presented.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b0;
        Cond = 4'h0; RegW = 1'b1; ex_valid = 1'b1; stall = 1'b0;
        PCS = 1'b0; MemW = 1'b1; FlagW = 2'b11; NoWrite = 1'b0;
        m_flags = 4'b0000; m_flush_left = 0; m_exec = 0; m_skip = 0;
        e.condex = 1'b0;
        e.pcsrc = 1'b0; e.regw = 1'b0; e.memw = 1'b0;
        e.flags = 4'b0000; e.flush = 1'b0; e.exec = 0; e.skip = 0;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        ex_valid = 1'b0; PCS = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        m_flags = 4'b0000; m_flush_left = 0; m_exec = 0; m_skip = 0;
        do_reset();

        // NoWrite compare sets Z, next EQ instruction then writes
        step(4'hE, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Partial flag write: N,Z only, then GE/LT
        do_reset();
        step(4'hE, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'hA, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'hB, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Taken branch with flag write, then squashed writes
        step(4'hE, 4'b0010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Stall inside flush stretches it to three cycles
        step(4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Never-execute and stalled AL
        step(4'hF, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset mid-flush
        step(4'hE, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // Counter saturation: 4 passing, 1 failing
        repeat (4) step(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'hF, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0));
        end

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            @(posedge clk);
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
